ysyx_25060166_lsu: RTL and testbench
====================================

Name: ysyx_25060166_lsu

Overview:
Load/store unit between the execute stage and the data-memory block. It accepts one memory operation per handshake and drives the memory's request, write-enable, half/byte flags and data. It waits for grant and read data, then sign- or zero-extends the load result. The result goes to writeback through a valid/ready handshake. Only one operation is in flight at a time, so the pipeline stalls while the LSU is busy.

Parameters:
WIDTH, 32, data and address width (RV32E)
RD_W, 4, destination register index width (16 registers)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  execute stage presents an operation
in_ready  out  1  LSU can accept an operation (state IDLE)
in_addr  in  WIDTH  byte address
in_wdata  in  WIDTH  store data; low lanes are used for half/byte stores
in_is_load  in  1  operation is a load
in_is_store  in  1  operation is a store; never asserted together with in_is_load
in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved
in_unsigned  in  1  zero-extend the load (LBU/LHU)
in_rd  in  RD_W  load destination register
mem_req  out  1  memory request, held until granted
mem_gnt  in  1  memory accepts the request this cycle
mem_we  out  1  request is a write
mem_addr  out  WIDTH  request address
mem_wdata  out  WIDTH  write data; integration wires [15:0] to half data and [7:0] to byte data
mem_half  out  1  half-word write
mem_byte  out  1  byte write
mem_rvalid  in  1  read data valid
mem_rdata  in  WIDTH  4 bytes read starting at mem_addr
out_valid  out  1  result available to writeback
out_ready  in  1  writeback accepts the result
out_rdata  out  WIDTH  extended load data; 0 for stores
out_rd  out  RD_W  destination register; 0 for stores
out_wen  out  1  writeback must write out_rd (loads only)
out_err  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state IDLE; all request registers cleared; mem_req, mem_we, mem_half, mem_byte, out_valid, out_wen and out_err are 0; out_rdata and out_rd are 0. in_ready is 1 from the first cycle after rst_n rises.
- Reset asserted mid-operation aborts the operation immediately. The memory sees mem_req fall, no result is produced, and any later mem_rvalid is ignored in IDLE.
- FSM IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE. Every transition happens on a clock edge. Outputs are decoded from state and registers, with no combinational path from in_* to mem_*.
- IDLE:
  - in_ready=1.
  - When in_valid is high, latch addr, wdata, size, unsigned, rd and kind.
  - A load or store goes to ISSUE.
  - If neither in_is_load nor in_is_store is set, go to DONE with out_wen=0 and out_rdata=0 (bubble).
- ISSUE:
  - mem_req=1, with mem_addr and mem_wdata from the latched values.
  - mem_we=is_store; mem_half=is_store&(size==1); mem_byte=is_store&(size==0).
  - If mem_gnt is low, stay in ISSUE with all mem_* outputs stable.
  - Store with mem_gnt -> DONE.
  - Load with mem_gnt and mem_rvalid in the same cycle -> capture the data, go to DONE.
  - Load with mem_gnt only -> WAIT.
- WAIT: mem_req=0. Stay until mem_rvalid, then capture the data and go to DONE.
- Load extraction from captured mem_rdata:
  - byte: data[7:0], zero-extended if unsigned, otherwise extended with bit 7.
  - half: data[15:0], extended from bit 15 in the same way.
  - word: all 32 bits unchanged.
- DONE: out_valid=1, with out_* held stable until out_ready. On out_valid&out_ready go to IDLE; in_ready rises in the following cycle.
- Latency: accept at edge N; out_valid is high in cycle N+2 at best (same-cycle grant and rvalid, or a store granted immediately). Each cycle without mem_gnt or mem_rvalid adds one cycle.
- Throughput: at most one operation per 3 cycles.

Optional Feature:
Macro YSYX_25060166_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, a word access with addr[1:0]!=0, or size==3 is a fault.
  - The fault goes IDLE -> DONE directly, with no mem_req.
  - The result is out_err=1, out_wen=0, out_rdata=0.
- Undefined:
  - out_err is tied to 0.
  - size==3 is treated as word.
  - Misaligned addresses go to memory unchanged.

Test Plan:
- Load byte addr 0x80000003, mem_rdata 0x000000F0, in_unsigned=0 -> out_rdata 0xFFFFFFF0, out_wen=1, out_rd as given.
- Same access with in_unsigned=1 -> 0x000000F0. LH on data 0x00008001 -> 0xFFFF8001.
- Store half 0x12345678 to 0x80000010 with mem_gnt held low 3 cycles -> mem_req high 4 cycles; mem_addr, mem_half=1 and mem_we=1 stable; out_valid 1 cycle after grant; out_wen=0.
- Load word with mem_rvalid 2 cycles after grant, out_ready low 2 cycles -> out_rdata held stable; in_ready low until the cycle after out_ready.
- rst_n pulsed low in WAIT -> mem_req=0 and out_valid=0 immediately. A later mem_rvalid is ignored. The next request completes normally.
- With MISALIGN_TRAP_EN: LW at 0x80000002 -> no mem_req, out_valid at N+1, out_err=1. Without it: mem_req is issued with mem_addr 0x80000002.

Source files
------------

// File: rtl/ysyx_25060166_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25060166_lsu
//
// Load/store unit between the execute stage and the data memory. It accepts
// one operation per in_valid/in_ready handshake and issues a single memory
// request. It waits for grant and read data, then sign- or zero-extends the
// load result and hands it to writeback over out_valid/out_ready. Only one
// operation is in flight, so in_ready is high only in IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_*                operation from execute: valid/ready, addr, wdata,
//                       is_load/is_store, size (0 B, 1 H, 2 W), unsigned, rd
//   mem_*               memory request: req held until gnt, we, half/byte
//                       write flags, addr, wdata; read data via rvalid/rdata
//   out_*               writeback: valid/ready, extended rdata, rd, wen, err
//
// Configuration
//   YSYX_25060166_LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word
//   accesses and size==3 skip memory and complete with out_err=1. When
//   undefined, out_err is 0, size==3 acts as word and addresses pass through.
// ---------------------------------------------------------------------------
module ysyx_25060166_lsu #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0] in_wdata,
    input  logic             in_is_load,
    input  logic             in_is_store,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [RD_W-1:0]  in_rd,

    output logic             mem_req,
    input  logic             mem_gnt,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_half,
    output logic             mem_byte,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rdata,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_wen,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [RD_W-1:0]  rd_q;
    logic             is_load_q;
    logic             is_store_q;
    logic [WIDTH-1:0] result_q;

    logic             in_fault;
    logic             accept;
    logic             capture;

    // ---------------------------------------------------------------------
    // Alignment fault detection (only a real memory op can fault; bubbles
    // never do).
    // ---------------------------------------------------------------------
`ifdef YSYX_25060166_LSU_MISALIGN_TRAP_EN
    logic err_q;

    always_comb begin
        in_fault = 1'b0;
        if (in_is_load || in_is_store) begin
            case (in_size)
                2'd1:    in_fault = in_addr[0];
                2'd2:    in_fault = (in_addr[1:0] != 2'b00);
                2'd3:    in_fault = 1'b1;
                default: in_fault = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= in_fault;
    end

    assign out_err = (state_q == S_DONE) && err_q;
`else
    assign in_fault = 1'b0;
    assign out_err  = 1'b0;
`endif

    assign accept  = (state_q == S_IDLE) && in_valid;
    // A load's data arrives either together with the grant or later in WAIT.
    assign capture = ((state_q == S_ISSUE) && mem_gnt && mem_rvalid && is_load_q)
                  || ((state_q == S_WAIT) && mem_rvalid);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_d; no latch inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_fault)
                        state_d = S_DONE;
                    else if (in_is_load || in_is_store)
                        state_d = S_ISSUE;
                    else
                        state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    if (is_store_q || mem_rvalid)
                        state_d = S_DONE;
                    else
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sign/zero extension of the captured read data according to size.
    function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       size,
                                                input logic             uns);
        logic [WIDTH-1:0] r;
        case (size)
            2'd0:    r = {{(WIDTH-8){~uns & d[7]}}, d[7:0]};
            2'd1:    r = {{(WIDTH-16){~uns & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State and request registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                size_q     <= in_size;
                unsigned_q <= in_unsigned;
                // Faulting ops and bubbles become no-write results.
                is_load_q  <= in_is_load  && !in_fault;
                is_store_q <= in_is_store && !in_fault;
                rd_q       <= (in_is_load && !in_fault) ? in_rd : '0;
                result_q   <= '0;
            end else if (capture) begin
                result_q <= extend(mem_rdata, size_q, unsigned_q);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs, decoded from state and registers only
    // ---------------------------------------------------------------------
    assign in_ready  = (state_q == S_IDLE);

    assign mem_req   = (state_q == S_ISSUE);
    assign mem_we    = mem_req && is_store_q;
    assign mem_half  = mem_req && is_store_q && (size_q == 2'd1);
    assign mem_byte  = mem_req && is_store_q && (size_q == 2'd0);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign out_valid = (state_q == S_DONE);
    assign out_rdata = result_q;
    assign out_rd    = rd_q;
    assign out_wen   = out_valid && is_load_q;

endmodule

// File: tb/tb_ysyx_25060166_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060166_lsu
//
// Directed bench for the LSU. Inputs are driven and outputs sampled on the
// falling clock edge; the memory side is played by hand inside run_op with
// configurable grant, read-data and writeback-ready delays.
// ---------------------------------------------------------------------------
module tb_ysyx_25060166_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [3:0]  in_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_half;
    logic        mem_byte;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ysyx_25060166_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_is_load (in_is_load),
        .in_is_store(in_is_store),
        .in_size    (in_size),
        .in_unsigned(in_unsigned),
        .in_rd      (in_rd),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_half   (mem_half),
        .mem_byte   (mem_byte),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_err    (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid    = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_size     = 2'd0;
        in_unsigned = 1'b0;
        in_rd       = '0;
    endtask

    // One complete operation. gnt_wait: cycles with mem_gnt low before the
    // grant; rv_wait: cycles from grant to mem_rvalid (0 = same cycle);
    // rdy_wait: cycles out_ready stays low in DONE. exp_mem=0 means the op
    // must not reach memory (bubble or trapped fault).
    task automatic run_op(input string name,
                          input bit ld, input bit st,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns,
                          input logic [3:0] rd, input logic [31:0] rdata,
                          input int gnt_wait, input int rv_wait, input int rdy_wait,
                          input logic [31:0] exp_rdata,
                          input bit exp_mem, input bit exp_err);
        logic        exp_wen;
        logic [3:0]  exp_rd;
        logic        exp_half;
        logic        exp_byte;
        exp_wen  = ld && !exp_err;
        exp_rd   = exp_wen ? rd : 4'd0;
        exp_half = st && (size == 2'd1);
        exp_byte = st && (size == 2'd0);

        check({name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_addr     = addr;
        in_wdata    = wdata;
        in_is_load  = ld;
        in_is_store = st;
        in_size     = size;
        in_unsigned = uns;
        in_rd       = rd;
        @(negedge clk);
        clear_inputs();

        if (exp_mem) begin
            for (int i = 0; i <= gnt_wait; i++) begin
                check({name, " mem_req"},   {31'd0, mem_req},  32'd1);
                check({name, " mem_addr"},  mem_addr,          addr);
                check({name, " mem_we"},    {31'd0, mem_we},   {31'd0, st});
                check({name, " mem_half"},  {31'd0, mem_half}, {31'd0, exp_half});
                check({name, " mem_byte"},  {31'd0, mem_byte}, {31'd0, exp_byte});
                if (st) check({name, " mem_wdata"}, mem_wdata, wdata);
                check({name, " issue out_valid"}, {31'd0, out_valid}, 32'd0);
                if (i == gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (ld && rv_wait == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                end
                @(negedge clk);
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (ld && rv_wait > 0) begin
                for (int i = 1; i <= rv_wait; i++) begin
                    check({name, " wait mem_req"},   {31'd0, mem_req},   32'd0);
                    check({name, " wait out_valid"}, {31'd0, out_valid}, 32'd0);
                    if (i == rv_wait) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
            end
        end else begin
            check({name, " no mem_req"}, {31'd0, mem_req}, 32'd0);
        end
        mem_rdata = 32'hDEAD_BEEF;

        for (int i = 0; i <= rdy_wait; i++) begin
            check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " out_rdata"}, out_rdata, exp_rdata);
            check({name, " out_wen"},   {31'd0, out_wen}, {31'd0, exp_wen});
            check({name, " out_rd"},    {28'd0, out_rd},  {28'd0, exp_rd});
            check({name, " out_err"},   {31'd0, out_err}, {31'd0, exp_err});
            check({name, " done in_ready"}, {31'd0, in_ready}, 32'd0);
            if (i == rdy_wait) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        check({name, " in_ready back"},  {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        clear_inputs();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst mem_req",   {31'd0, mem_req},   32'd0);
        check("rst mem_we",    {31'd0, mem_we},    32'd0);
        check("rst mem_half",  {31'd0, mem_half},  32'd0);
        check("rst mem_byte",  {31'd0, mem_byte},  32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_wen",   {31'd0, out_wen},   32'd0);
        check("rst out_err",   {31'd0, out_err},   32'd0);
        check("rst out_rdata", out_rdata,          32'd0);
        check("rst out_rd",    {28'd0, out_rd},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      name   ld st addr          wdata         sz uns rd    rdata         gw rw rdy exp_rdata     mem err
        run_op("LB",   1, 0, 32'h8000_0003, 32'h0,       0, 0, 4'd5, 32'h0000_00F0, 0, 0, 0, 32'hFFFF_FFF0, 1, 0);
        run_op("LBU",  1, 0, 32'h8000_0003, 32'h0,       0, 1, 4'd6, 32'h0000_00F0, 0, 0, 0, 32'h0000_00F0, 1, 0);
        run_op("LH",   1, 0, 32'h8000_0004, 32'h0,       1, 0, 4'd7, 32'h0000_8001, 0, 0, 0, 32'hFFFF_8001, 1, 0);
        run_op("LHU",  1, 0, 32'h8000_0006, 32'h0,       1, 1, 4'd8, 32'hABCD_F001, 1, 1, 0, 32'h0000_F001, 1, 0);
        run_op("LBp",  1, 0, 32'h8000_0001, 32'h0,       0, 0, 4'd9, 32'h1234_5675, 0, 1, 0, 32'h0000_0075, 1, 0);
        run_op("SH",   0, 1, 32'h8000_0010, 32'h1234_5678, 1, 0, 4'd3, 32'h0,       3, 0, 0, 32'h0,        1, 0);
        run_op("SB",   0, 1, 32'h8000_0021, 32'hCAFE_00A5, 0, 0, 4'd2, 32'h0,       0, 0, 1, 32'h0,        1, 0);
        run_op("SW",   0, 1, 32'h8000_0024, 32'h0BAD_F00D, 2, 0, 4'd1, 32'h0,       1, 0, 0, 32'h0,        1, 0);
        run_op("LW",   1, 0, 32'h8000_0008, 32'h0,       2, 0, 4'hF, 32'h8765_4321, 0, 2, 2, 32'h8765_4321, 1, 0);
        run_op("BUB",  0, 0, 32'h8000_0030, 32'h0,       2, 0, 4'd4, 32'h0,       0, 0, 1, 32'h0,        0, 0);

        // Reset while waiting for read data aborts the load.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_addr    = 32'h8000_0040;
        in_size    = 2'd2;
        in_rd      = 4'd10;
        @(negedge clk);
        clear_inputs();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("wait_rst pre mem_req", {31'd0, mem_req},  32'd0);
        check("wait_rst pre in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("wait_rst mem_req",   {31'd0, mem_req},   32'd0);
        check("wait_rst out_valid", {31'd0, out_valid}, 32'd0);
        check("wait_rst in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late rvalid out_valid", {31'd0, out_valid}, 32'd0);
        check("late rvalid mem_req",   {31'd0, mem_req},   32'd0);
        run_op("LWpost", 1, 0, 32'h8000_0044, 32'h0, 2, 0, 4'd11, 32'h1357_9BDF, 0, 1, 0, 32'h1357_9BDF, 1, 0);

`ifdef YSYX_25060166_LSU_MISALIGN_TRAP_EN
        run_op("LWmis", 1, 0, 32'h8000_0002, 32'h0, 2, 0, 4'd12, 32'h0, 0, 0, 0, 32'h0, 0, 1);
        run_op("SHmis", 0, 1, 32'h8000_0011, 32'h1, 1, 0, 4'd0,  32'h0, 0, 0, 0, 32'h0, 0, 1);
`else
        run_op("LWmis", 1, 0, 32'h8000_0002, 32'h0, 2, 0, 4'd12, 32'h2468_ACE0, 0, 0, 0, 32'h2468_ACE0, 1, 0);
        run_op("LSZ3",  1, 0, 32'h8000_0004, 32'h0, 3, 0, 4'd13, 32'hF0F0_0F0F, 0, 0, 0, 32'hF0F0_0F0F, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
